diff_rank_selector: RTL and testbench

Downstream stage of the alphabet-matching pipeline: consumes the stream of per-letter difference scores (address from the letter counter, magnitude from the subtractor/memory path), one entry per cycle, and ranks them. At end of frame, presents the best and second-best matching letter addresses, their scores and the entry count, held under a valid/ready handshake until the next stage (translator output) takes them.

---
 rtl/diff_rank_selector.sv | 178 +++++++++++++++++
 tb/tb_diff_rank_selector.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_rank_selector.sv
// Purpose : ranks a frame of per-letter difference scores and keeps the best and second-best (smallest) entries.
// Latency : the result registers load on the edge that accepts IN_LAST, so OUT_VALID is seen the following cycle.
// Backpr. : IN_READY is low while a result is held; it is held until OUT_VALID & OUT_READY, then a new frame is accepted.
//
// Ports:
//   CLK, RST (async, active-low)
//   IN_VALID / IN_READY / IN_ADDR / IN_DIFF / IN_LAST : entry stream, one entry per cycle
//   OUT_VALID / OUT_READY : result handshake
//   BEST_ADDR / BEST_DIFF, SECOND_ADDR / SECOND_DIFF, ENTRY_CNT, NO_MATCH : registered result
//
// Optional feature: define DRS_THRESHOLD_EN to drive NO_MATCH = (final best diff > THRESH).
// Without it, NO_MATCH is tied low and no comparator is built.
module diff_rank_selector #(
  parameter int unsigned           ADDR_W = 6,
  parameter int unsigned           DIFF_W = 12,
  parameter int unsigned           CNT_W  = ADDR_W + 1,
  parameter logic [DIFF_W-1:0]     THRESH = 12'd64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [ADDR_W-1:0] IN_ADDR,
  input  logic [DIFF_W-1:0] IN_DIFF,
  input  logic              IN_LAST,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [ADDR_W-1:0] BEST_ADDR,
  output logic [DIFF_W-1:0] BEST_DIFF,
  output logic [ADDR_W-1:0] SECOND_ADDR,
  output logic [DIFF_W-1:0] SECOND_DIFF,
  output logic [CNT_W-1:0]  ENTRY_CNT,
  output logic              NO_MATCH
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t              state;
  logic                in_ready_q;
  logic                out_valid_q;

  // Running ranking for the frame in progress.
  logic [ADDR_W-1:0]   run_best_addr;
  logic [DIFF_W-1:0]   run_best_diff;
  logic [ADDR_W-1:0]   run_sec_addr;
  logic [DIFF_W-1:0]   run_sec_diff;
  logic [CNT_W-1:0]    run_cnt;

  // Ranking including the entry currently presented.
  logic                accept;
  logic [ADDR_W-1:0]   nxt_best_addr;
  logic [DIFF_W-1:0]   nxt_best_diff;
  logic [ADDR_W-1:0]   nxt_sec_addr;
  logic [DIFF_W-1:0]   nxt_sec_diff;
  logic [CNT_W-1:0]    nxt_cnt;

  // Registered result.
  logic [ADDR_W-1:0]   best_addr_q;
  logic [DIFF_W-1:0]   best_diff_q;
  logic [ADDR_W-1:0]   sec_addr_q;
  logic [DIFF_W-1:0]   sec_diff_q;
  logic [CNT_W-1:0]    cnt_q;

  assign accept = IN_VALID & in_ready_q;

  // Strict less-than everywhere, so an equal score never displaces an
  // earlier entry.
  always_comb begin
    nxt_best_addr = run_best_addr;
    nxt_best_diff = run_best_diff;
    nxt_sec_addr  = run_sec_addr;
    nxt_sec_diff  = run_sec_diff;
    if (IN_DIFF < run_best_diff) begin
      nxt_sec_addr  = run_best_addr;
      nxt_sec_diff  = run_best_diff;
      nxt_best_addr = IN_ADDR;
      nxt_best_diff = IN_DIFF;
    end else if (IN_DIFF < run_sec_diff) begin
      nxt_sec_addr  = IN_ADDR;
      nxt_sec_diff  = IN_DIFF;
    end
    nxt_cnt = (&run_cnt) ? run_cnt : run_cnt + 1'b1;
  end

`ifdef DRS_THRESHOLD_EN
  logic no_match_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      run_best_addr <= '0;
      run_best_diff <= '1;
      run_sec_addr  <= '0;
      run_sec_diff  <= '1;
      run_cnt       <= '0;
      best_addr_q   <= '0;
      best_diff_q   <= '0;
      sec_addr_q    <= '0;
      sec_diff_q    <= '0;
      cnt_q         <= '0;
`ifdef DRS_THRESHOLD_EN
      no_match_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, ACCUM: begin
          // Also brings IN_READY up on the first edge after reset release.
          in_ready_q <= 1'b1;
          if (accept) begin
            if (IN_LAST) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              best_addr_q <= nxt_best_addr;
              best_diff_q <= nxt_best_diff;
              sec_addr_q  <= nxt_sec_addr;
              sec_diff_q  <= nxt_sec_diff;
              cnt_q       <= nxt_cnt;
`ifdef DRS_THRESHOLD_EN
              no_match_q  <= (nxt_best_diff > THRESH);
`endif
              // The running ranking is cleared now; nothing reads it in
              // HOLD, so the next frame starts from a clean slate.
              run_best_addr <= '0;
              run_best_diff <= '1;
              run_sec_addr  <= '0;
              run_sec_diff  <= '1;
              run_cnt       <= '0;
            end else begin
              state         <= ACCUM;
              run_best_addr <= nxt_best_addr;
              run_best_diff <= nxt_best_diff;
              run_sec_addr  <= nxt_sec_addr;
              run_sec_diff  <= nxt_sec_diff;
              run_cnt       <= nxt_cnt;
            end
          end
        end
        HOLD: begin
          if (OUT_READY) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef DRS_THRESHOLD_EN
            no_match_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY    = in_ready_q;
  assign OUT_VALID   = out_valid_q;
  assign BEST_ADDR   = best_addr_q;
  assign BEST_DIFF   = best_diff_q;
  assign SECOND_ADDR = sec_addr_q;
  assign SECOND_DIFF = sec_diff_q;
  assign ENTRY_CNT   = cnt_q;

`ifdef DRS_THRESHOLD_EN
  assign NO_MATCH = no_match_q;
`else
  // THRESH only matters with the threshold feature; this parity wire has no
  // load and disappears in synthesis.
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign NO_MATCH      = 1'b0;
`endif

endmodule

// File: tb/tb_diff_rank_selector.sv
// Self-checking bench for diff_rank_selector: a frame-level reference model
// (queue of accepted entries, ranked by scanning at end of frame) compared
// every cycle, plus hand-computed expectations for the directed frames.
module tb_diff_rank_selector;

  localparam int ADDR_W = 6;
  localparam int DIFF_W = 12;
  localparam int CNT_W  = 7;
  localparam int THR    = 64;

  logic              CLK;
  logic              RST;
  logic              IN_VALID;
  logic              IN_READY;
  logic [ADDR_W-1:0] IN_ADDR;
  logic [DIFF_W-1:0] IN_DIFF;
  logic              IN_LAST;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [ADDR_W-1:0] BEST_ADDR;
  logic [DIFF_W-1:0] BEST_DIFF;
  logic [ADDR_W-1:0] SECOND_ADDR;
  logic [DIFF_W-1:0] SECOND_DIFF;
  logic [CNT_W-1:0]  ENTRY_CNT;
  logic              NO_MATCH;

  diff_rank_selector dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_ADDR    (IN_ADDR),
    .IN_DIFF    (IN_DIFF),
    .IN_LAST    (IN_LAST),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .BEST_ADDR  (BEST_ADDR),
    .BEST_DIFF  (BEST_DIFF),
    .SECOND_ADDR(SECOND_ADDR),
    .SECOND_DIFF(SECOND_DIFF),
    .ENTRY_CNT  (ENTRY_CNT),
    .NO_MATCH   (NO_MATCH)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          q_addr[$];
  int          q_diff[$];
  logic        m_ready, m_valid, m_fresh, m_nm;
  int          m_ba, m_bd, m_sa, m_sd, m_cnt;

  // Best = earliest entry with the smallest score; second = earliest entry
  // with the smallest score among all the others (none -> all-ones / 0).
  task automatic rank_frame();
    int bi, si, n;
    n  = q_diff.size();
    bi = 0;
    for (int i = 1; i < n; i++) if (q_diff[i] < q_diff[bi]) bi = i;
    si = -1;
    for (int i = 0; i < n; i++)
      if (i != bi && (si < 0 || q_diff[i] < q_diff[si])) si = i;
    m_ba = q_addr[bi];
    m_bd = q_diff[bi];
    m_sa = (si < 0) ? 0 : q_addr[si];
    m_sd = (si < 0) ? 'hFFF : q_diff[si];
    m_cnt = (n > 127) ? 127 : n;
`ifdef DRS_THRESHOLD_EN
    m_nm = (m_bd > THR);
`else
    m_nm = 1'b0;
`endif
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_ready = 1'b0; m_valid = 1'b0; m_fresh = 1'b1; m_nm = 1'b0;
      m_ba = 0; m_bd = 0; m_sa = 0; m_sd = 0; m_cnt = 0;
      q_addr.delete(); q_diff.delete();
    end else if (m_valid) begin
      if (OUT_READY) begin
        m_valid = 1'b0; m_ready = 1'b1; m_nm = 1'b0;
      end
    end else begin
      if (IN_VALID && m_ready) begin
        q_addr.push_back(int'(IN_ADDR));
        q_diff.push_back(int'(IN_DIFF));
        if (IN_LAST) begin
          rank_frame();
          m_valid = 1'b1; m_fresh = 1'b0;
          q_addr.delete(); q_diff.delete();
        end
      end
      m_ready = !m_valid;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge CLK) begin
    chk("in_ready", IN_READY, m_ready);
    chk("out_valid", OUT_VALID, m_valid);
    chk("no_match", NO_MATCH, m_nm);
    if (m_valid || m_fresh) begin
      chk("best_addr", BEST_ADDR, m_ba);
      chk("best_diff", BEST_DIFF, m_bd);
      chk("sec_addr", SECOND_ADDR, m_sa);
      chk("sec_diff", SECOND_DIFF, m_sd);
      chk("entry_cnt", ENTRY_CNT, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  // Present one entry and hold it until accepted (bounded).
  task automatic send(input int a, input int d, input logic last);
    logic r;
    int   n;
    IN_VALID = 1'b1;
    IN_ADDR  = a[ADDR_W-1:0];
    IN_DIFF  = d[DIFF_W-1:0];
    IN_LAST  = last;
    n = 0;
    do begin
      r = IN_READY;
      @(posedge CLK); #2;
      n++;
    end while (!r && n < 50);
    if (!r) chk("send_timeout", 0, 1);
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  // Called right after the IN_LAST entry was accepted.
  task automatic expect_result(input string tag, input int ba, input int bd,
                               input int sa, input int sd, input int cnt);
    chk({tag, "_valid"}, OUT_VALID, 1);
    chk({tag, "_rdy_low"}, IN_READY, 0);
    chk({tag, "_ba"}, BEST_ADDR, ba);
    chk({tag, "_bd"}, BEST_DIFF, bd);
    chk({tag, "_sa"}, SECOND_ADDR, sa);
    chk({tag, "_sd"}, SECOND_DIFF, sd);
    chk({tag, "_cnt"}, ENTRY_CNT, cnt);
  endtask

  task automatic release_result(input string tag);
    OUT_READY = 1'b1;
    @(posedge CLK); #2;
    OUT_READY = 1'b0;
    chk({tag, "_rel_valid"}, OUT_VALID, 0);
    chk({tag, "_rel_ready"}, IN_READY, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b0; IN_VALID = 1'b0; IN_ADDR = '0; IN_DIFF = '0; IN_LAST = 1'b0;
    OUT_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_ready", IN_READY, 0);
    chk("rst_valid", OUT_VALID, 0);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #2;
    chk("post_rst_ready", IN_READY, 1);

    // Reset in the middle of a frame.
    send(0, 100, 0); send(1, 50, 0); send(2, 75, 0);
    RST = 1'b0; #1;
    chk("midrst_ready", IN_READY, 0);
    chk("midrst_cnt", ENTRY_CNT, 0);
    chk("midrst_bd", BEST_DIFF, 0);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #2;

    // Basic frame; count restarts from 1 after the reset.
    send(0, 40, 0); send(1, 12, 0); send(2, 7, 0); send(3, 30, 1);
    expect_result("basic", 2, 7, 1, 12, 4);
    release_result("basic");

    // Ties: earlier arrival wins.
    send(10, 5, 0); send(11, 5, 0); send(12, 5, 1);
    expect_result("ties", 10, 5, 11, 5, 3);
    release_result("ties");

    // Single-entry frame.
    send(9, 3, 1);
    expect_result("single", 9, 3, 0, 'hFFF, 1);
    release_result("single");

    // Later best pushes earlier best into second.
    send(5, 7, 0); send(6, 3, 0); send(7, 7, 1);
    expect_result("displace", 6, 3, 5, 7, 3);
    release_result("displace");

    // Backpressure: result held while consumer stalls, input ignored.
    send(20, 200, 0); send(21, 150, 1);
    for (int i = 0; i < 5; i++) begin
      IN_VALID = 1'b1; IN_ADDR = 6'd40; IN_DIFF = 12'd2; IN_LAST = 1'b1;
      @(posedge CLK); #2;
      chk("bp_ready", IN_READY, 0);
      chk("bp_ba", BEST_ADDR, 21);
      chk("bp_cnt", ENTRY_CNT, 2);
    end
    // Handshake cycle with a coincident entry: not accepted in that cycle,
    // then taken as a one-entry frame on the next edge.
    IN_ADDR = 6'd33; IN_DIFF = 12'd1; IN_LAST = 1'b1;
    OUT_READY = 1'b1;
    @(posedge CLK); #2;
    OUT_READY = 1'b0;
    chk("hs_valid", OUT_VALID, 0);
    chk("hs_ready", IN_READY, 1);
    @(posedge CLK); #2;
    IN_VALID = 1'b0; IN_LAST = 1'b0;
    expect_result("after_bp", 33, 1, 0, 'hFFF, 1);
    release_result("after_bp");

    // Threshold boundary (NO_MATCH checked by the model each cycle too).
    send(1, 80, 0); send(2, 65, 1);
`ifdef DRS_THRESHOLD_EN
    chk("thr65", NO_MATCH, 1);
`else
    chk("thr65", NO_MATCH, 0);
`endif
    release_result("thr65");
    chk("thr_clr", NO_MATCH, 0);
    send(3, 64, 0); send(4, 90, 1);
    chk("thr64", NO_MATCH, 0);
    release_result("thr64");

    // Long frame: count saturates at 127, addresses wrap.
    for (int i = 0; i < 130; i++)
      send(i, 3000 - ((i * 37) % 2900), (i == 129));
    chk("sat_cnt", ENTRY_CNT, 127);
    chk("sat_valid", OUT_VALID, 1);
    release_result("sat");

    // Consumer ready while nothing is valid has no effect.
    OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    OUT_READY = 1'b0;
    chk("idle_oready", OUT_VALID, 0);

    // Reset while holding a result.
    send(8, 11, 1);
    RST = 1'b0; #1;
    chk("holdrst_valid", OUT_VALID, 0);
    chk("holdrst_ba", BEST_ADDR, 0);
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(posedge CLK);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
